// File: rtl/tensor_core_sequencer.sv
// Sequencer around small_tensor_core: gathers 18 operand bytes into two 3x3 matrices,
// launches the core, captures one result per counter step and streams the nine results out.
module tensor_core_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         tensor_core_clock,
  input  logic                         reset_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]                   op_select,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         busy,
  output logic signed [DATA_WIDTH-1:0] core_input1 [3][3],
  output logic signed [DATA_WIDTH-1:0] core_input2 [3][3],
  output logic                         core_write_enable,
  output logic                         core_start,
  output logic [1:0]                   core_operation_select,
  input  logic signed [DATA_WIDTH-1:0] core_output [3][3]
);

  localparam int N_ELEM = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    COMPUTE,
    DRAIN
  } state_t;

  state_t                       state;
  logic [4:0]                   load_idx;
  logic [3:0]                   cap_idx;
  logic [3:0]                   drain_idx;
  logic signed [DATA_WIDTH-1:0] result [N_ELEM];
  logic                         accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge tensor_core_clock) begin
    if (!reset_in) begin
      state                 <= IDLE;
      load_idx              <= '0;
      cap_idx               <= '0;
      drain_idx             <= '0;
      for (int i = 0; i < N_ELEM; i++) begin
        result[i]               <= '0;
        core_input1[i/3][i%3]   <= '0;
        core_input2[i/3][i%3]   <= '0;
      end
      core_operation_select <= 2'b00;
      in_ready              <= 1'b0;
      out_valid             <= 1'b0;
      out_data              <= '0;
      busy                  <= 1'b0;
      core_start            <= 1'b0;
      // Holding write-enable parks the core's element counter at 9.
      core_write_enable     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          in_ready          <= 1'b1;
          core_write_enable <= 1'b1;
          core_start        <= 1'b0;
          out_valid         <= 1'b0;
          out_data          <= '0;
          busy              <= 1'b0;
          if (accept) begin
            core_input1[0][0]     <= in_data;
            core_operation_select <= op_select;
            load_idx              <= 5'd1;
            busy                  <= 1'b1;
            state                 <= LOAD;
          end
        end

        LOAD: begin
          if (accept) begin
            for (int i = 0; i < N_ELEM; i++) begin
              if (load_idx == 5'(i))          core_input1[i/3][i%3] <= in_data;
              if (load_idx == 5'(i + N_ELEM)) core_input2[i/3][i%3] <= in_data;
            end
            if (load_idx == 5'(2*N_ELEM - 1)) begin
              in_ready          <= 1'b0;
              core_write_enable <= 1'b0;
              core_start        <= 1'b1;
              state             <= LAUNCH;
            end else begin
              load_idx <= load_idx + 5'd1;
            end
          end
        end

        LAUNCH: begin
          core_start <= 1'b0;
          cap_idx    <= '0;
          state      <= COMPUTE;
        end

        COMPUTE: begin
          // The core counter equals cap_idx during this cycle.
          for (int i = 0; i < N_ELEM; i++) begin
            if (cap_idx == 4'(i)) result[i] <= core_output[i/3][i%3];
          end
          if (cap_idx == 4'(N_ELEM - 1)) begin
            out_valid         <= 1'b1;
            out_data          <= result[0];
            drain_idx         <= '0;
            core_write_enable <= 1'b1;
            state             <= DRAIN;
          end else begin
            cap_idx <= cap_idx + 4'd1;
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (drain_idx == 4'(N_ELEM - 1)) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              drain_idx <= drain_idx + 4'd1;
              for (int i = 0; i < N_ELEM - 1; i++) begin
                if (drain_idx == 4'(i)) out_data <= result[i+1];
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tensor_core_sequencer.md
Name: tensor_core_sequencer

Overview:
- Wraps `small_tensor_core` on both sides.
- Upstream, it accepts a byte stream of operands and assembles the two 3x3 signed operand matrices that drive the core inputs.
- It then launches the core and captures one result element per cycle as the core walks its element counter.
- Downstream, it streams the 9 captured results out over a valid/ready interface.
- It is the only block that drives the core's write-enable, start and operation-select pins.

Parameters:
- DATA_WIDTH, 8, element width (signed), equal to `BUS_WIDTH+1` of the core.
- N_ELEM, 9, elements per matrix (3x3, row-major). Fixed; not for override.

Ports:
- tensor_core_clock  in  1  single clock; every register updates on its rising edge.
- reset_in  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  sequencer can accept a byte.
- in_data  in  DATA_WIDTH  operand byte, signed.
- op_select  in  2  operation (00 matmul, 01 add, 1x relu); sampled with the first accepted byte of a load.
- out_valid  out  1  result byte valid.
- out_ready  in  1  downstream accepts the result byte.
- out_data  out  DATA_WIDTH  result byte, signed.
- busy  out  1  high in every state except IDLE.
- core_input1  out  [3][3] x DATA_WIDTH  operand A to the core.
- core_input2  out  [3][3] x DATA_WIDTH  operand B to the core.
- core_write_enable  out  1  to the core's `tensor_core_register_file_write_enable`.
- core_start  out  1  to the core's `should_start_tensor_core`.
- core_operation_select  out  2  to the core's `operation_select`.
- core_output  in  [3][3] x DATA_WIDTH  from the core's `tensor_core_output`.

Behaviour:
- Reset:
  - reset_in sampled low at a rising edge forces state IDLE.
  - Load index, capture index and drain index go to 0.
  - Operand and result buffers clear to 0; latched op clears to 00.
  - All handshake outputs are registered.
  - While reset_in is low: in_ready=0, out_valid=0, busy=0, core_start=0, core_write_enable=1 (parks the core counter at 9).
  - The first cycle after release: in_ready=1.
- States: IDLE, LOAD, LAUNCH, COMPUTE, DRAIN.
- Byte ordering: bytes 0-8 fill core_input1 row-major ([b/3][b%3]); bytes 9-17 fill core_input2 row-major. All 18 bytes are required for every op, even where the core ignores input2.
- IDLE:
  - in_ready=1, core_write_enable=1.
  - On in_valid&in_ready: store byte 0 and latch op_select into core_operation_select. Go to LOAD with index=1.
- LOAD:
  - in_ready=1, core_write_enable=1.
  - Each handshake stores one byte and increments the index. Gaps (in_valid=0) are simply waited out.
  - The handshake on byte 17 moves to LAUNCH.
  - in_ready must be 0 in the cycle after byte 17 is accepted.
- LAUNCH (exactly 1 cycle):
  - core_write_enable=0, core_start=1.
  - Next state COMPUTE with capture index k=0.
- COMPUTE (exactly 9 cycles):
  - core_write_enable=0, core_start=0.
  - In cycle k, the core counter equals k; register core_output[k/3][k%3] into result[k] at the end of the cycle.
  - After k=8 is captured, go to DRAIN.
  - Launch-to-last-capture latency: 10 cycles after the LAUNCH cycle begins.
- DRAIN:
  - out_valid=1, out_data=result[j].
  - On out_valid&out_ready: j increments and out_data updates in the same registered step.
  - out_valid and out_data hold stable while out_ready=0.
  - Accepting j=8 returns to IDLE with out_valid=0 the next cycle.
- Port behaviour by state:
  - Operands stay driven and unchanged from LAUNCH through DRAIN.
  - in_data is ignored whenever in_ready=0.
  - out_data is 0 whenever out_valid=0.
- Arithmetic: none in this block. Results are the core's 8-bit outputs, which the core truncates mod 2^8.
- Reset mid-operation: reset in any state aborts the transaction. Partial operands and results are discarded and the block returns to IDLE as specified above. No out_valid appears for the aborted job.
- Simultaneous events: in_valid in the LAUNCH/COMPUTE/DRAIN states is not accepted. A back-to-back job is accepted only once IDLE is re-entered.

Test Plan:
- Matmul: op 00, A=[1..9] row-major, B=identity -> out stream 1,2,3,4,5,6,7,8,9; LAUNCH is exactly 1 cycle; out_valid rises 10 cycles after core_start.
- Add: op 01, A=[1..9], B all -1 -> 0,1,2,3,4,5,6,7,8.
- Relu: op 10, A=[-5,3,-128,127,0,-1,2,-2,1], B arbitrary -> 0,3,0,127,0,0,2,0,1.
- Overflow: op 00, A and B all 10 -> nine bytes of 44 (300 mod 256).
- Backpressure and gaps: in_valid toggles every other cycle during LOAD; out_ready low for 3 cycles at j=4 -> out_data holds result[4] with out_valid=1; sequence intact; busy falls after byte 8.
- Reset mid-COMPUTE at k=4 -> next cycle IDLE, in_ready=1, out_valid never asserted; a following identity job returns A unchanged.
